// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores to TXDATA queue bytes in a FIFO and the
// serialiser drains it. A dropped push (FIFO full) sets a sticky overrun flag.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  adr,
  input  logic        w,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        txd,
  output logic        irq
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  logic [BW-1:0]  baud;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [AW:0]    count;
  logic           ovr, ie;
  logic           full, empty, busy;
  logic           push_req, push, pop, ovr_clr;
  logic [31:0]    cnt32;
  logic           unused_wd;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = sel & w & (adr == 2'd0);
  assign push     = push_req & ~full;
  assign pop      = (state == IDLE) & ~empty;
  assign ovr_clr  = sel & w & (adr == 2'd1) & wd[3];
  assign irq      = ie & empty & ~busy;
  assign cnt32    = 32'(count);
  assign unused_wd = ^wd[31:8];

  always_comb begin
    rd = '0;
    if (sel) begin
      case (adr)
        2'd1:    rd = {24'b0, cnt32[3:0], ovr, busy, empty, full};
        2'd2:    rd = {31'b0, ie};
        default: rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovr   <= 1'b0;
      ie    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Overrun wins over nothing: a full-FIFO push is lost even when a pop frees a slot this edge.
      if (ovr_clr)             ovr <= 1'b0;
      if (push_req && full)    ovr <= 1'b1;
      if (sel && w && adr == 2'd2) ie <= wd[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shift <= mem[rptr];
            state <= START;
            baud  <= '0;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          txd <= 1'b1;
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
